// File: rtl/fir_sample_scheduler.sv
// rtl/fir_sample_scheduler.sv - buffers IIS samples, sequences them through the FIR with timeout, returns results
module fir_sample_scheduler #(
   parameter int DATA_SIZE         = 16,
   parameter int DATA_SIZE_FIR_OUT = 32,
   parameter int FIFO_DEPTH        = 4,
   parameter int TIMEOUT_CYCLES    = 480
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         cfg_enable_i,
   input  logic                         cfg_bypass_i,
   input  logic                         clear_cnt_i,
   input  logic                         iis_valid_i,
   input  logic [DATA_SIZE-1:0]         iis_data_i,
   output logic                         fir_req_o,
   output logic [DATA_SIZE-1:0]         fir_data_o,
   input  logic                         fir_ack_i,
   input  logic                         fir_done_i,
   input  logic [DATA_SIZE_FIR_OUT-1:0] fir_result_i,
   output logic                         out_valid_o,
   output logic [DATA_SIZE_FIR_OUT-1:0] out_data_o,
   output logic                         busy_o,
   output logic [7:0]                   overflow_cnt_o,
   output logic [7:0]                   timeout_cnt_o
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
   localparam int EXT_W = DATA_SIZE_FIR_OUT - DATA_SIZE;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DELIVER
   } state_t;

   state_t                        state_q, state_d;
   logic [DATA_SIZE-1:0]          fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]              wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]              count_q;
   logic [DATA_SIZE-1:0]          head;
   logic                          fifo_empty, fifo_full;
   logic                          push, pop, drop;
   logic                          ld_bypass, ld_result, ld_timeout, tmr_clr;
   logic                          timeout_hit;
   logic [TMR_W-1:0]              timer_q;
   logic [DATA_SIZE-1:0]          shadow_q;
   logic                          fir_req_q, out_valid_q;
   logic [DATA_SIZE_FIR_OUT-1:0]  out_data_q;
   logic [7:0]                    ovf_cnt_q, tmo_cnt_q;

   function automatic logic [DATA_SIZE_FIR_OUT-1:0] sext(input logic [DATA_SIZE-1:0] s);
      return {{EXT_W{s[DATA_SIZE-1]}}, s};
   endfunction

   assign head        = fifo_mem[rd_ptr_q];
   assign fifo_empty  = (count_q == '0);
   assign fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
   assign timeout_hit = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

   // A full FIFO still accepts a sample when the head leaves in the same cycle.
   assign push = iis_valid_i && cfg_enable_i && (!fifo_full || pop);
   assign drop = iis_valid_i && cfg_enable_i && fifo_full && !pop;

   // Next-state and datapath strobes; disable forces IDLE with no pops.
   always_comb begin
      state_d    = state_q;
      pop        = 1'b0;
      ld_bypass  = 1'b0;
      ld_result  = 1'b0;
      ld_timeout = 1'b0;
      tmr_clr    = 1'b0;
      if (!cfg_enable_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!fifo_empty) begin
                  if (cfg_bypass_i) begin
                     pop       = 1'b1;
                     ld_bypass = 1'b1;
                     state_d   = S_DELIVER;
                  end else begin
                     state_d = S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               if (fir_ack_i) begin
                  pop     = 1'b1;
                  tmr_clr = 1'b1;
                  state_d = S_WAIT;
               end
            end
            S_WAIT: begin
               if (fir_done_i) begin
                  ld_result = 1'b1;
                  state_d   = S_DELIVER;
               end else if (timeout_hit) begin
                  ld_timeout = 1'b1;
                  state_d    = S_DELIVER;
               end
            end
            S_DELIVER: state_d = S_IDLE;
            default:   state_d = S_IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // FIFO storage; contents are only observed through a valid head.
   always_ff @(posedge clk_i) begin
      if (push) fifo_mem[wr_ptr_q] <= iis_data_i;
   end

   // FIFO pointers and occupancy; disable empties the queue.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (!cfg_enable_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // WAIT timer, restarted on the FIR ack; shadow keeps the sample for the timeout path.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         timer_q  <= '0;
         shadow_q <= '0;
      end else if (tmr_clr) begin
         timer_q  <= '0;
         shadow_q <= head;
      end else if (state_q == S_WAIT) begin
         timer_q  <= timer_q + TMR_W'(1);
      end
   end

   // Registered handshake and delivery outputs, decoded from the next state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fir_req_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         fir_req_q   <= (state_d == S_ISSUE);
         out_valid_q <= (state_d == S_DELIVER);
         if (ld_bypass)       out_data_q <= sext(head);
         else if (ld_result)  out_data_q <= fir_result_i;
         else if (ld_timeout) out_data_q <= sext(shadow_q);
      end
   end

   // Saturating event counters; clear beats a coincident increment.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ovf_cnt_q <= '0;
         tmo_cnt_q <= '0;
      end else if (clear_cnt_i) begin
         ovf_cnt_q <= '0;
         tmo_cnt_q <= '0;
      end else begin
         if (drop && (ovf_cnt_q != 8'hFF))       ovf_cnt_q <= ovf_cnt_q + 8'd1;
         if (ld_timeout && (tmo_cnt_q != 8'hFF)) tmo_cnt_q <= tmo_cnt_q + 8'd1;
      end
   end

   assign fir_req_o      = fir_req_q;
   assign fir_data_o     = (state_q == S_ISSUE) ? head : '0;
   assign out_valid_o    = out_valid_q;
   assign out_data_o     = out_data_q;
   assign busy_o         = (state_q != S_IDLE) || !fifo_empty;
   assign overflow_cnt_o = ovf_cnt_q;
   assign timeout_cnt_o  = tmo_cnt_q;

endmodule
